// File: rtl/maxpool2d_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pooling stage.
//   pool_state_e : frame-sequencer states
//   clog2        : ceiling log2 for width derivation
//   max2         : 32-bit max, signed or unsigned selected by argument
package maxpool2d_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pool_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while (r < 32 && (64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Callers sign- or zero-extend narrower samples before calling.
  function automatic logic [31:0] max2(input logic [31:0] a, input logic [31:0] b,
                                       input logic is_signed);
    if (is_signed) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool2d_if.sv
// Pixel-stream bundle for the max-pooling stage.
//   master : upstream side (drives frame size, fin_start, din_vld, din)
//   slave  : pooling stage (drives fout_start, dout_vld, dout, out_frame_h/w)
interface maxpool2d_if
  import maxpool2d_pkg::*;
#(
  parameter int unsigned FRAME_H_MAX = 224,
  parameter int unsigned FRAME_W_MAX = 224,
  parameter int unsigned DIN_WIDTH   = 8,
  parameter int unsigned CH_NUM      = 128
);
  localparam int unsigned CNT_H_W = clog2(FRAME_H_MAX) + 1;
  localparam int unsigned CNT_W_W = clog2(FRAME_W_MAX) + 1;

  logic [CNT_H_W-1:0]                frame_h;
  logic [CNT_W_W-1:0]                frame_w;
  logic                              fin_start;
  logic                              din_vld;
  logic [CH_NUM-1:0][DIN_WIDTH-1:0]  din;
  logic                              fout_start;
  logic                              dout_vld;
  logic [CH_NUM-1:0][DIN_WIDTH-1:0]  dout;
  logic [CNT_H_W-1:0]                out_frame_h;
  logic [CNT_W_W-1:0]                out_frame_w;

  modport master (
    output frame_h, frame_w, fin_start, din_vld, din,
    input  fout_start, dout_vld, dout, out_frame_h, out_frame_w
  );

  modport slave (
    input  frame_h, frame_w, fin_start, din_vld, din,
    output fout_start, dout_vld, dout, out_frame_h, out_frame_w
  );
endinterface

// File: rtl/maxpool2d_pool_line_buffer.sv
// Simple dual-port RAM holding the even-row pair maxima for one pooled row.
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr         : synchronous read request
//   o_rdata              : read data, valid the cycle after i_re, held until next read
module pool_line_buffer #(
  parameter int unsigned DEPTH = 112,
  parameter int unsigned AW    = 7,
  parameter int unsigned DW    = 1024
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Storage is intentionally unreset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/maxpool2d.sv
// 2x2 stride-2 max pooling over a raster pixel stream, all channels in parallel.
//   clk, reset : clock, asynchronous active-high reset
//   io_pool    : stream bundle (frame size, fin_start/din_vld/din in;
//                fout_start/dout_vld/dout and halved frame size out)
module maxpool2d
  import maxpool2d_pkg::*;
#(
  parameter int unsigned FRAME_H_MAX = 224,
  parameter int unsigned FRAME_W_MAX = 224,
  parameter int unsigned DIN_WIDTH   = 8,
  parameter int unsigned CH_NUM      = 128,
  parameter int unsigned DATA_SIGNED = 1
) (
  input  logic          clk,
  input  logic          reset,
  maxpool2d_if.slave    io_pool
);
  localparam int unsigned CNT_H_W  = clog2(FRAME_H_MAX) + 1;
  localparam int unsigned CNT_W_W  = clog2(FRAME_W_MAX) + 1;
  localparam int unsigned LB_DEPTH = FRAME_W_MAX / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? clog2(LB_DEPTH) : 1;
  localparam int unsigned PIX_W    = CH_NUM * DIN_WIDTH;

  typedef logic [CH_NUM-1:0][DIN_WIDTH-1:0] pix_t;

  pool_state_e         r_state, w_state_nxt;
  logic [CNT_H_W-1:0]  r_row, w_row_nxt, w_row;
  logic [CNT_W_W-1:0]  r_col, w_col_nxt, w_col;
  logic                w_beat, w_last_col, w_last;
  logic                w_lb_we, w_lb_re, w_h_we, w_out;
  logic [LB_AW-1:0]    w_lb_addr;
  pix_t                r_h, r_dout, w_pair, w_quad, w_lb_rdata;
  logic                r_fout_start, r_dout_vld;

  function automatic logic [DIN_WIDTH-1:0] ch_max(input logic [DIN_WIDTH-1:0] a,
                                                  input logic [DIN_WIDTH-1:0] b);
    logic [31:0] ea;
    logic [31:0] eb;
    ea = (DATA_SIGNED != 0) ? 32'($signed(a)) : 32'(a);
    eb = (DATA_SIGNED != 0) ? 32'($signed(b)) : 32'(b);
    return DIN_WIDTH'(max2(ea, eb, DATA_SIGNED != 0));
  endfunction

  // Sequencer state and raster position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Next state; a fin_start beat is pixel (0,0) of the new frame.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_row       = io_pool.fin_start ? '0 : r_row;
    w_col       = io_pool.fin_start ? '0 : r_col;
    w_beat      = io_pool.din_vld && (io_pool.fin_start || (r_state == ST_RUN));
    w_last_col  = (w_col == io_pool.frame_w - CNT_W_W'(1));
    w_last      = w_last_col && (w_row == io_pool.frame_h - CNT_H_W'(1));
    if (io_pool.fin_start) begin
      w_state_nxt = ST_RUN;
      w_row_nxt   = '0;
      w_col_nxt   = '0;
    end
    if (w_beat) begin
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_row_nxt   = '0;
        w_col_nxt   = '0;
      end else if (w_last_col) begin
        w_row_nxt   = w_row + CNT_H_W'(1);
        w_col_nxt   = '0;
      end else begin
        w_col_nxt   = w_col + CNT_W_W'(1);
      end
    end
  end

  // Window-position decode; odd trailing row/column never reach an odd,odd slot.
  assign w_h_we    = w_beat && !w_col[0];
  assign w_lb_we   = w_beat && !w_row[0] &&  w_col[0];
  assign w_lb_re   = w_beat &&  w_row[0] && !w_col[0];
  assign w_out     = w_beat &&  w_row[0] &&  w_col[0];
  assign w_lb_addr = LB_AW'(w_col >> 1);

  always_comb begin
    w_pair = '0;
    w_quad = '0;
    for (int ch = 0; ch < int'(CH_NUM); ch++) begin
      w_pair[ch] = ch_max(r_h[ch], io_pool.din[ch]);
      w_quad[ch] = ch_max(w_pair[ch], w_lb_rdata[ch]);
    end
  end

  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW),
    .DW    (PIX_W)
  ) u_lb (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_addr),
    .i_wdata (w_pair),
    .i_re    (w_lb_re),
    .i_raddr (w_lb_addr),
    .o_rdata (w_lb_rdata)
  );

  // Datapath registers; dout holds between valid beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h          <= '0;
      r_dout       <= '0;
      r_dout_vld   <= 1'b0;
      r_fout_start <= 1'b0;
    end else begin
      r_fout_start <= io_pool.fin_start;
      r_dout_vld   <= w_out;
      if (w_h_we) r_h    <= io_pool.din;
      if (w_out)  r_dout <= w_quad;
    end
  end

  assign io_pool.fout_start  = r_fout_start;
  assign io_pool.dout_vld    = r_dout_vld;
  assign io_pool.dout        = r_dout;
  assign io_pool.out_frame_h = io_pool.frame_h >> 1;
  assign io_pool.out_frame_w = io_pool.frame_w >> 1;
endmodule
